pmem_line_adapter: RTL
======================

// Module: pmem_line_adapter
// PURPOSE
//  Downstream neighbour of the 2-way cache controller. Converts one cache-line request
//  (pmem_read/pmem_write, 128-bit line) into a burst of narrow 16-bit beats on the memory bus.
//  Returns a single-cycle pmem_resp once the whole line has been transferred.
//  Sits between the cache datapath/controller and the physical memory bus.
// PARAMETERS
//  LINE_WIDTH  128  cache line width in bits
//  BEAT_WIDTH  16   memory bus data width in bits; BEATS = LINE_WIDTH/BEAT_WIDTH = 8
//  ADDR_WIDTH  16   byte address width
// PORTS
//  clk           in   1           clock; all state changes on its rising edge
//  reset_n       in   1           synchronous reset, active-low
//  pmem_read     in   1           line read request from cache; held until pmem_resp
//  pmem_write    in   1           line write-back request from cache; held until pmem_resp
//  pmem_address  in   ADDR_WIDTH  line address; bits [3:0] ignored (line aligned)
//  pmem_wdata    in   LINE_WIDTH  write-back line data
//  pmem_rdata    out  LINE_WIDTH  assembled read line; valid while pmem_resp=1
//  pmem_resp     out  1           one-cycle completion pulse
//  bus_req       out  1           beat request to memory bus
//  bus_we        out  1           1 = write beat, 0 = read beat
//  bus_addr      out  ADDR_WIDTH  beat byte address
//  bus_wdata     out  BEAT_WIDTH  write beat data
//  bus_rdata     in   BEAT_WIDTH  read beat data; sampled when bus_ready=1
//  bus_ready     in   1           beat accepted/completed this cycle
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - state = IDLE, beat counter = 0, all outputs 0 (pmem_rdata included).
//   - Mid-burst reset aborts the burst: bus_req=0 from the next cycle, no pmem_resp,
//     partial read data discarded.
//  States: IDLE -> XFER -> DONE -> IDLE.
//  IDLE:
//   - If pmem_write or pmem_read: capture line_addr = pmem_address[15:4],
//     wbuf = pmem_wdata and we = pmem_write, clear counter, go to XFER.
//   - Both requests asserted together: write wins (evacuation precedes refill).
//  XFER:
//   - bus_req=1, bus_we=we, bus_addr={line_addr, cnt[2:0], 1'b0}, bus_wdata=wbuf[16*cnt +: 16].
//   - Outputs are registered/stable for the whole beat; they may change only after bus_ready.
//   - bus_ready=0: hold everything (unbounded wait states allowed).
//   - bus_ready=1: read -> rbuf[16*cnt +: 16] <= bus_rdata; cnt++.
//   - cnt==BEATS-1 with bus_ready=1: go to DONE; bus_req=0 in DONE.
//  DONE:
//   - pmem_resp=1 for exactly one cycle, then IDLE.
//   - pmem_rdata = rbuf and holds until the next read's first beat lands (write-back leaves it unchanged).
//  Latency: request sampled at edge E0, beats complete at E1..E8 with bus_ready held 1,
//   pmem_resp high in the cycle after E8 (9 cycles minimum); each wait state adds 1.
//  Request inputs and pmem_wdata are ignored outside IDLE (snapshot semantics).
//  A request still high in the IDLE cycle after DONE starts a new transaction; the cache
//   controller leaves its request state on pmem_resp, so this does not occur in normal operation.
//  Counter is log2(BEATS) bits, no wrap beyond BEATS-1; beat addresses never leave the line.
// TESTING
//  1 Read, addr 0x1234, bus_ready=1 always, bus_rdata=beat idx -> bus_addr 0x1230..0x123E step 2,
//    pmem_resp at cycle 9, pmem_rdata=0x0007_0006_..._0000.
//  2 Write, addr 0xABC0, wdata=0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> bus_we=1,
//    bus_wdata 0x3210,0x7654,...,0x0123 in order, single pmem_resp.
//  3 Read with bus_ready low 2 cycles on beat 3 -> beat-3 outputs frozen, pmem_resp at cycle 11,
//    data correct.
//  4 pmem_read and pmem_write both high -> write burst only; change pmem_wdata mid-burst ->
//    bus_wdata still the captured line.
//  5 reset_n=0 during beat 4 of a read -> bus_req=0 next cycle, pmem_resp never fires,
//    pmem_rdata=0; a new read then completes normally.
//  6 Write-back then read back-to-back, as in the cache controller's evacuate-then-load flow ->
//    two resp pulses, IDLE gap of 1 cycle, read data unaffected by write.

Source files
------------

// File: rtl/pmem_line_adapter_if.sv
// Cache-side line request signals and memory-side beat bus of the line adapter.
// The slave modport is the adapter's view; master is the cache/memory environment.
interface pmem_line_adapter_if #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned BEAT_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [BEAT_WIDTH-1:0] bus_wdata;
  logic [BEAT_WIDTH-1:0] bus_rdata;
  logic                  bus_ready;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, bus_rdata, bus_ready,
    input  pmem_rdata, pmem_resp, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, bus_rdata, bus_ready,
    output pmem_rdata, pmem_resp, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/pmem_line_adapter.sv
// Splits one cache-line read/write-back into a burst of narrow beats on the memory bus
// and returns a single-cycle pmem_resp once the whole line has moved.
module pmem_line_adapter #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned BEAT_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic               clk,
  input logic               reset_n,
  pmem_line_adapter_if.slave pmem
);
  localparam int unsigned BEATS    = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W    = $clog2(BEATS);
  localparam int unsigned BEAT_LSB = $clog2(BEAT_WIDTH / 8);
  localparam int unsigned LINE_LSB = CNT_W + BEAT_LSB;
  localparam int unsigned TAG_W    = ADDR_WIDTH - LINE_LSB;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [TAG_W-1:0]               line_q, line_d;
  logic                           we_q, we_d;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] rbuf_q, rbuf_d;
  logic                           last_beat;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      we_q    <= we_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    we_d    = we_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;

    pmem.bus_req   = 1'b0;
    pmem.bus_we    = 1'b0;
    pmem.bus_addr  = '0;
    pmem.bus_wdata = '0;
    pmem.pmem_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A simultaneous read+write is treated as a write: eviction goes out before refill.
        if (pmem.pmem_read || pmem.pmem_write) begin
          line_d  = pmem.pmem_address[ADDR_WIDTH-1:LINE_LSB];
          wbuf_d  = pmem.pmem_wdata;
          we_d    = pmem.pmem_write;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        pmem.bus_req   = 1'b1;
        pmem.bus_we    = we_q;
        pmem.bus_addr  = {line_q, cnt_q, {BEAT_LSB{1'b0}}};
        pmem.bus_wdata = wbuf_q[cnt_q];
        if (pmem.bus_ready) begin
          if (!we_q) begin
            rbuf_d[cnt_q] = pmem.bus_rdata;
          end
          if (last_beat) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        pmem.pmem_resp = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pmem.pmem_rdata = rbuf_q;
endmodule
